axis_unpack: RTL and testbench
==============================

Name: axis_unpack

Overview:
- AXI-Stream width down-converter. Accepts IN_WIDTH-bit words from an upstream fifo and emits them as a stream of OUT_WIDTH-bit symbols.
- Sits at the drain end of the transmit buffering, between the word fifo and symbol-rate consumers such as the mapper or serializer.
- Sustains one symbol per clock with no bubbles between words, and preserves packet boundaries via tlast.

Parameters:
IN_WIDTH, 32, input word width; must be an integer multiple of OUT_WIDTH
OUT_WIDTH, 8, output symbol width
LSB_FIRST, 1, 1 = emit bits [OUT_WIDTH-1:0] first; 0 = emit most-significant slice first

Ports:
aclk  input  1  clock, rising edge
aresetn  input  1  asynchronous active-low reset
s_axis_tdata  input  IN_WIDTH  input word
s_axis_tvalid  input  1  input word valid
s_axis_tready  output  1  block can accept a word this cycle
s_axis_tlast  input  1  word is the final word of its packet
m_axis_tdata  output  OUT_WIDTH  current symbol
m_axis_tvalid  output  1  symbol valid
m_axis_tready  input  1  downstream accepts the symbol
m_axis_tlast  output  1  final symbol of the packet

Behaviour:
- RATIO = IN_WIDTH/OUT_WIDTH. Elaboration must fail if IN_WIDTH % OUT_WIDTH != 0.
- State:
  - word register: IN_WIDTH data plus 1 last bit.
  - full flag.
  - slice index idx, clog2(RATIO) bits; 1 bit minimum when RATIO = 1.
- Reset (aresetn low, asynchronous):
  - full = 0, idx = 0, word register = 0.
  - Outputs: m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
  - s_axis_tready is combinational and therefore 1 while full = 0.
- Handshakes: in_hs = s_axis_tvalid & s_axis_tready; out_hs = m_axis_tvalid & m_axis_tready.
- Output drive:
  - m_axis_tvalid = full.
  - m_axis_tdata = slice idx of the word register: bits [idx*OUT_WIDTH +: OUT_WIDTH] if LSB_FIRST, else the mirrored slice.
  - m_axis_tlast = stored last & (idx == RATIO-1).
- Input ready: s_axis_tready = ~full | (m_axis_tready & idx == RATIO-1). This gives zero-bubble chaining from one word to the next.
- Per-cycle update, evaluated in priority order:
  1. out_hs and idx != RATIO-1: idx <= idx+1; the word is held.
  2. out_hs and idx == RATIO-1: idx <= 0. If in_hs in the same cycle, load the new word and last, full stays 1. Otherwise full <= 0.
  3. No out_hs and in_hs (implies full = 0): load word and last, full <= 1, idx <= 0.
- Latency: a word accepted on edge N presents its first symbol from N+1 onward.
- Throughput: 1 symbol per cycle with both sides always ready; one word every RATIO cycles.
- AXI rules:
  - Once asserted, m_axis_tvalid never drops until out_hs.
  - m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid & ~m_axis_tready.
  - s_axis_tready may depend combinationally on m_axis_tready. No other combinational path from s to m.
- Boundary conditions:
  - Back-pressure mid-word: idx and data freeze; no symbol is lost or duplicated.
  - Empty with s_axis_tvalid = 0: m_axis_tvalid = 0 and idx stays 0.
  - RATIO = 1: behaves as a single-stage register slice, with s_axis_tready = ~full | m_axis_tready.
  - s_axis_tlast on a word with RATIO > 1: only the last symbol of that word carries m_axis_tlast.
  - Reset mid-word: remaining symbols are discarded. After release, the first symbol produced belongs to the next accepted word.
  - Input data is ignored when in_hs = 0.

Test Plan:
- Reset, then send word 0x44332211 (tlast = 1) with m_axis_tready = 1 -> m_axis_tvalid goes high one cycle after the handshake. Symbols are 0x11, 0x22, 0x33, 0x44 on consecutive cycles; m_axis_tlast is high only with 0x44; m_axis_tvalid is low the following cycle.
- Stream words 1..10 back-to-back with both sides always ready -> 40 symbols with no m_axis_tvalid gaps. s_axis_tready pulses high once every 4 cycles after the first load. The output sequence is 01,00,00,00,02,00,00,00,...,0A,00,00,00.
- Same 10-word stream with m_axis_tready toggling 1,0,0,1 repeating -> identical symbol sequence. tdata and tlast are stable during every stall; no loss or duplication against the scoreboard.
- LSB_FIRST = 0, send 0xAABBCCDD -> symbols AA, BB, CC, DD in that order.
- Assert aresetn low after the second symbol of 0x44332211, release, then send 0x88776655 -> m_axis_tvalid = 0 during reset. The next symbols are 0x55, 0x66, 0x77, 0x88; no 0x33 or 0x44 appears.
- IN_WIDTH = OUT_WIDTH = 32, chain two instances, fill with 1..10 and hold m_axis_tready = 0 -> s_axis_tready drops after 2 words accepted. Releasing m_axis_tready drains 1..10 in order, after which m_axis_tvalid falls.

Source files
------------

// File: rtl/axis_unpack.sv
// rtl/axis_unpack.sv - AXI-Stream width down-converter, IN_WIDTH words to OUT_WIDTH symbols
module axis_unpack #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  generate
    if (IN_WIDTH % OUT_WIDTH != 0) begin : g_width_check
      $error("axis_unpack: IN_WIDTH must be an integer multiple of OUT_WIDTH");
    end
  endgenerate

  logic [IN_WIDTH-1:0] word_q;
  logic                last_q;
  logic                full_q;
  logic [IDX_W-1:0]    idx_q;
  logic                at_last;
  logic                in_hs;
  logic                out_hs;
  logic [IDX_W-1:0]    sel;

  assign at_last       = (idx_q == LAST_IDX);
  assign m_axis_tvalid = full_q;
  assign m_axis_tlast  = last_q & at_last;
  // Ready on the final slice lets the next word load on the same edge the last symbol leaves.
  assign s_axis_tready = ~full_q | (m_axis_tready & at_last);
  assign in_hs         = s_axis_tvalid & s_axis_tready;
  assign out_hs        = m_axis_tvalid & m_axis_tready;
  assign sel           = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);

  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (sel == IDX_W'(i)) begin
        m_axis_tdata = word_q[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      word_q <= '0;
      last_q <= 1'b0;
      full_q <= 1'b0;
      idx_q  <= '0;
    end else if (out_hs) begin
      if (!at_last) begin
        idx_q <= idx_q + IDX_W'(1);
      end else begin
        idx_q <= '0;
        if (in_hs) begin
          word_q <= s_axis_tdata;
          last_q <= s_axis_tlast;
        end else begin
          full_q <= 1'b0;
        end
      end
    end else if (in_hs) begin
      word_q <= s_axis_tdata;
      last_q <= s_axis_tlast;
      full_q <= 1'b1;
      idx_q  <= '0;
    end
  end

endmodule

// File: tb/tb_axis_unpack.sv
// tb/tb_axis_unpack.sv - directed vector bench for axis_unpack
module tb_axis_unpack;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [31:0] d_sdata;
  logic        d_svalid, d_slast, d_sready;
  logic [7:0]  d_mdata;
  logic        d_mvalid, d_mready, d_mlast;

  logic [31:0] r_sdata;
  logic        r_svalid, r_slast, r_sready;
  logic [7:0]  r_mdata;
  logic        r_mvalid, r_mready, r_mlast;

  logic [31:0] c_sdata, mid_data, c_mdata;
  logic        c_svalid, c_slast, c_sready;
  logic        mid_valid, mid_ready, mid_last;
  logic        c_mvalid, c_mready, c_mlast;

  axis_unpack #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(d_sdata), .s_axis_tvalid(d_svalid), .s_axis_tready(d_sready), .s_axis_tlast(d_slast),
    .m_axis_tdata(d_mdata), .m_axis_tvalid(d_mvalid), .m_axis_tready(d_mready), .m_axis_tlast(d_mlast)
  );

  axis_unpack #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(r_sdata), .s_axis_tvalid(r_svalid), .s_axis_tready(r_sready), .s_axis_tlast(r_slast),
    .m_axis_tdata(r_mdata), .m_axis_tvalid(r_mvalid), .m_axis_tready(r_mready), .m_axis_tlast(r_mlast)
  );

  axis_unpack #(.IN_WIDTH(32), .OUT_WIDTH(32), .LSB_FIRST(1'b1)) dut_c1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(c_sdata), .s_axis_tvalid(c_svalid), .s_axis_tready(c_sready), .s_axis_tlast(c_slast),
    .m_axis_tdata(mid_data), .m_axis_tvalid(mid_valid), .m_axis_tready(mid_ready), .m_axis_tlast(mid_last)
  );

  axis_unpack #(.IN_WIDTH(32), .OUT_WIDTH(32), .LSB_FIRST(1'b1)) dut_c2 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(mid_data), .s_axis_tvalid(mid_valid), .s_axis_tready(mid_ready), .s_axis_tlast(mid_last),
    .m_axis_tdata(c_mdata), .m_axis_tvalid(c_mvalid), .m_axis_tready(c_mready), .m_axis_tlast(c_mlast)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Output scoreboards plus stall-stability watch on the default instance
  logic [7:0]  got_d[$];
  logic        got_l[$];
  int          got_c[$];
  logic [31:0] cq_d[$];
  logic        cq_l[$];
  logic        st_prev = 1'b0;
  logic [7:0]  st_data = '0;
  logic        st_last = 1'b0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      st_prev <= 1'b0;
    end else begin
      if (st_prev) begin
        chk("stall_valid", {31'b0, d_mvalid}, 32'd1);
        chk("stall_data", {24'b0, d_mdata}, {24'b0, st_data});
        chk("stall_last", {31'b0, d_mlast}, {31'b0, st_last});
      end
      if (d_mvalid && d_mready) begin
        got_d.push_back(d_mdata);
        got_l.push_back(d_mlast);
        got_c.push_back(cyc);
      end
      if (c_mvalid && c_mready) begin
        cq_d.push_back(c_mdata);
        cq_l.push_back(c_mlast);
      end
      st_prev <= d_mvalid && !d_mready;
      st_data <= d_mdata;
      st_last <= d_mlast;
    end
  end

  int acc_q[$];

  task automatic send_word(input logic [31:0] d, input logic l);
    bit ok = 1'b0;
    d_sdata  = d;
    d_slast  = l;
    d_svalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge aclk);
      if (d_sready) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    else acc_q.push_back(cyc);
    tick();
    d_svalid = 1'b0;
    d_sdata  = $urandom;
    d_slast  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_syms(input int n);
    for (int i = 0; i < 600 && got_d.size() < n; i++) tick();
    chk("wait_syms", {31'b0, got_d.size() >= n}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] din;
    logic        lst;
    logic [7:0]  e0, e1, e2, e3;
  } vec_t;
  vec_t tbl[5];

  logic pat[4];

  initial begin
    logic [7:0] ex;
    int nacc;
    bit hs;

    tbl[0] = '{32'h44332211, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44};
    tbl[1] = '{32'hAABBCCDD, 1'b0, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    tbl[2] = '{32'h80000001, 1'b1, 8'h01, 8'h00, 8'h00, 8'h80};
    tbl[3] = '{32'h00FF00FF, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00};
    tbl[4] = '{32'h12345678, 1'b1, 8'h78, 8'h56, 8'h34, 8'h12};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    aresetn  = 1'b0;
    d_sdata  = 32'hDEADBEEF; d_svalid = 1'b0; d_slast = 1'b1; d_mready = 1'b1;
    r_sdata  = '0; r_svalid = 1'b0; r_slast = 1'b0; r_mready = 1'b1;
    c_sdata  = '0; c_svalid = 1'b0; c_slast = 1'b0; c_mready = 1'b0;
    tick(); tick();
    chk("rst_mvalid", {31'b0, d_mvalid}, 32'd0);
    chk("rst_mlast", {31'b0, d_mlast}, 32'd0);
    chk("rst_mdata", {24'b0, d_mdata}, 32'd0);
    chk("rst_sready", {31'b0, d_sready}, 32'd1);
    chk("rst_chain_mvalid", {31'b0, c_mvalid}, 32'd0);
    aresetn = 1'b1;
    tick(); tick();
    chk("idle_mvalid", {31'b0, d_mvalid}, 32'd0);

    // Single words, both sides ready
    for (int v = 0; v < 5; v++) begin
      send_word(tbl[v].din, tbl[v].lst);
      for (int k = 0; k < 4; k++) begin
        case (k)
          0: ex = tbl[v].e0;
          1: ex = tbl[v].e1;
          2: ex = tbl[v].e2;
          default: ex = tbl[v].e3;
        endcase
        chk("vec_valid", {31'b0, d_mvalid}, 32'd1);
        chk("vec_data", {24'b0, d_mdata}, {24'b0, ex});
        chk("vec_last", {31'b0, d_mlast}, {31'b0, tbl[v].lst && k == 3});
        tick();
      end
      chk("vec_done_valid", {31'b0, d_mvalid}, 32'd0);
    end

    // Back-to-back stream of words 1..10
    got_d.delete(); got_l.delete(); got_c.delete(); acc_q.delete();
    for (int w = 1; w <= 10; w++) send_word(32'(w), w == 10);
    wait_syms(40);
    chk("stream_count", got_d.size(), 32'd40);
    for (int i = 0; i < 40 && i < got_d.size(); i++) begin
      chk("stream_data", {24'b0, got_d[i]}, (i % 4 == 0) ? 32'(i / 4 + 1) : 32'd0);
      chk("stream_last", {31'b0, got_l[i]}, {31'b0, i == 39});
    end
    if (got_c.size() >= 40 && acc_q.size() >= 10) begin
      chk("stream_first_latency", got_c[0], acc_q[0] + 1);
      chk("stream_no_gaps", got_c[39] - got_c[0], 32'd39);
      for (int i = 1; i < 10; i++) chk("stream_accept_spacing", acc_q[i] - acc_q[i-1], 32'd4);
    end
    chk("stream_end_valid", {31'b0, d_mvalid}, 32'd0);

    // Same stream under 1,0,0,1 back-pressure
    got_d.delete(); got_l.delete(); got_c.delete(); acc_q.delete();
    fork
      begin
        for (int w = 1; w <= 10; w++) send_word(32'(w), w == 10);
      end
      begin
        for (int c = 0; c < 600 && got_d.size() < 40; c++) begin
          d_mready = pat[c % 4];
          tick();
        end
        d_mready = 1'b1;
      end
    join
    chk("bp_count", got_d.size(), 32'd40);
    for (int i = 0; i < 40 && i < got_d.size(); i++) begin
      chk("bp_data", {24'b0, got_d[i]}, (i % 4 == 0) ? 32'(i / 4 + 1) : 32'd0);
      chk("bp_last", {31'b0, got_l[i]}, {31'b0, i == 39});
    end
    tick();
    chk("bp_end_valid", {31'b0, d_mvalid}, 32'd0);

    // Most-significant slice first
    r_sdata = 32'hAABBCCDD; r_slast = 1'b1; r_svalid = 1'b1;
    @(negedge aclk);
    chk("msb_sready", {31'b0, r_sready}, 32'd1);
    tick();
    r_svalid = 1'b0; r_sdata = 32'h01234567;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: ex = 8'hAA;
        1: ex = 8'hBB;
        2: ex = 8'hCC;
        default: ex = 8'hDD;
      endcase
      chk("msb_valid", {31'b0, r_mvalid}, 32'd1);
      chk("msb_data", {24'b0, r_mdata}, {24'b0, ex});
      chk("msb_last", {31'b0, r_mlast}, {31'b0, k == 3});
      tick();
    end
    chk("msb_done_valid", {31'b0, r_mvalid}, 32'd0);

    // Reset after the second symbol of a word
    d_mready = 1'b1;
    send_word(32'h44332211, 1'b1);
    tick(); tick();
    chk("mid_pre_reset_data", {24'b0, d_mdata}, 32'h33);
    aresetn = 1'b0;
    #1;
    got_d.delete(); got_l.delete(); got_c.delete();
    chk("mid_rst_valid", {31'b0, d_mvalid}, 32'd0);
    chk("mid_rst_data", {24'b0, d_mdata}, 32'd0);
    chk("mid_rst_last", {31'b0, d_mlast}, 32'd0);
    tick(); tick();
    chk("mid_rst_hold_valid", {31'b0, d_mvalid}, 32'd0);
    aresetn = 1'b1;
    tick();
    chk("mid_post_valid", {31'b0, d_mvalid}, 32'd0);
    send_word(32'h88776655, 1'b0);
    wait_syms(4);
    tick(); tick(); tick();
    chk("mid_count", got_d.size(), 32'd4);
    for (int i = 0; i < 4 && i < got_d.size(); i++)
      chk("mid_data", {24'b0, got_d[i]}, 32'h55 + 32'(i) * 32'h11);

    // Two chained RATIO=1 slices under full back-pressure
    c_mready = 1'b0; c_sdata = 32'd1; c_slast = 1'b0; c_svalid = 1'b1;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      hs = c_sready;
      tick();
      if (hs) begin
        nacc++;
        c_sdata = 32'(nacc + 1);
        c_slast = (nacc + 1 == 10);
      end
    end
    chk("chain_accepted", nacc, 32'd2);
    @(negedge aclk);
    chk("chain_sready_low", {31'b0, c_sready}, 32'd0);
    tick();
    c_mready = 1'b1;
    for (int i = 0; i < 200 && nacc < 10; i++) begin
      @(negedge aclk);
      hs = c_sready;
      tick();
      if (hs) begin
        nacc++;
        c_sdata = 32'(nacc + 1);
        c_slast = (nacc + 1 == 10);
      end
    end
    c_svalid = 1'b0;
    for (int i = 0; i < 50 && cq_d.size() < 10; i++) tick();
    chk("chain_count", cq_d.size(), 32'd10);
    for (int i = 0; i < 10 && i < cq_d.size(); i++) begin
      chk("chain_data", cq_d[i], 32'(i + 1));
      chk("chain_last", {31'b0, cq_l[i]}, {31'b0, i == 9});
    end
    tick();
    chk("chain_end_valid", {31'b0, c_mvalid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
